// File: rtl/cpu_pkg.sv
// Shared CPU memory-subsystem definitions: default bus widths and the data RAM
// clear/ready state encoding.
package cpu_pkg;
    localparam int CPU_DATA_WIDTH = 8;
    localparam int CPU_ADDR_WIDTH = 8;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_READY = 1'b1
    } ram_state_t;
endpackage

// File: rtl/ram_param_if.sv
// Request/response bundle between the CPU control unit (master) and the data RAM (slave).
interface ram_param_if import cpu_pkg::*; #(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  rd_err;
    logic                  busy;

    modport master (
        output req_valid, write_enable, address, data_in,
        input  req_ready, data_out, rd_valid, rd_err, busy
    );

    modport slave (
        input  req_valid, write_enable, address, data_in,
        output req_ready, data_out, rd_valid, rd_err, busy
    );
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every implemented word once, then hands the
// memory over to the request port.
module ram_clear_seq import cpu_pkg::*; #(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RAM_CLEAR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == RAM_CLEAR) begin
            if (addr_q == LAST_ADDR) state_d = RAM_READY;
            else                     addr_d  = addr_q + 1'b1;
        end
    end

    assign busy     = (state_q == RAM_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = addr_q;
endmodule

// File: rtl/ram_param.sv
// Parametrised single-port data RAM with valid/ready requests, registered reads,
// out-of-range flagging and a hardware clear after reset.
module ram_param import cpu_pkg::*; #(
    parameter int                    DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int                    DEPTH      = 2 ** ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst,
    ram_param_if.slave  bus
);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and never wraps.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  busy, clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  accept, in_range, rd_en, wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy      = busy;
    assign bus.req_ready = !busy;

    assign accept   = bus.req_valid && bus.req_ready;
    assign in_range = {1'b0, bus.address} < DEPTH_W;
    assign rd_en    = accept && !bus.write_enable;

    // Clear owns the write port whenever busy; requests are never accepted then.
    assign wr_en   = clr_we || (accept && bus.write_enable && in_range);
    assign wr_addr = clr_we ? clr_addr   : bus.address;
    assign wr_data = clr_we ? INIT_VALUE : bus.data_in;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
        end else begin
            bus.rd_valid <= rd_en;
            if (rd_en) begin
                if (in_range) begin
                    bus.data_out <= mem[bus.address];
                    bus.rd_err   <= 1'b0;
                end else begin
                    bus.data_out <= INIT_VALUE;
                    bus.rd_err   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_param.sv
// Randomized self-checking bench for ram_param: two instances (full depth and a
// short depth with non-zero fill) checked against an array-based memory model.
module tb_ram_param;
    import cpu_pkg::*;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    ram_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus0 ();
    ram_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus1 ();

    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .INIT_VALUE(8'h00))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .INIT_VALUE(8'hA5))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word arrays plus the last read result per instance.
    logic [7:0] mdl [2][256];
    int         dep [2] = '{256, 200};
    logic [7:0] ini [2] = '{8'h00, 8'hA5};
    logic [7:0] exp_do [2];
    logic       exp_err [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input int s, input bit v, input bit we, input logic [7:0] a,
                         input logic [7:0] d);
        if (s == 0) begin
            bus0.req_valid = v; bus0.write_enable = we; bus0.address = a; bus0.data_in = d;
        end else begin
            bus1.req_valid = v; bus1.write_enable = we; bus1.address = a; bus1.data_in = d;
        end
    endtask

    task automatic sample(input int s, output logic [7:0] dout, output logic rdv,
                          output logic err, output logic rdy, output logic bsy);
        if (s == 0) begin
            dout = bus0.data_out; rdv = bus0.rd_valid; err = bus0.rd_err;
            rdy = bus0.req_ready; bsy = bus0.busy;
        end else begin
            dout = bus1.data_out; rdv = bus1.rd_valid; err = bus1.rd_err;
            rdy = bus1.req_ready; bsy = bus1.busy;
        end
    endtask

    // One accepted request per call; signals are left asserted so calls chain back-to-back.
    task automatic op(input int s, input bit we, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] dout; logic rdv, err, rdy, bsy, exp_rdv;
        sample(s, dout, rdv, err, rdy, bsy);
        chk("req_ready", rdy, 1);
        drive(s, 1'b1, we, a, d);
        @(posedge clk); #1;
        if (we) begin
            if (int'(a) < dep[s]) mdl[s][a] = d;
            exp_rdv = 1'b0;
        end else begin
            exp_do[s]  = (int'(a) < dep[s]) ? mdl[s][a] : ini[s];
            exp_err[s] = (int'(a) >= dep[s]);
            exp_rdv    = 1'b1;
        end
        sample(s, dout, rdv, err, rdy, bsy);
        chk(we ? "wr_rd_valid" : "rd_valid", rdv, exp_rdv);
        chk("data_out", dout, exp_do[s]);
        chk("rd_err", err, exp_err[s]);
    endtask

    task automatic idle(input int s);
        logic [7:0] dout; logic rdv, err, rdy, bsy;
        drive(s, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        sample(s, dout, rdv, err, rdy, bsy);
        chk("idle_rd_valid", rdv, 0);
        chk("idle_hold_data", dout, exp_do[s]);
        chk("idle_hold_err", err, exp_err[s]);
    endtask

    // Reset both instances; optionally re-pulse reset after `glitch` clear steps and/or
    // hold a read of address 5 on instance 0 throughout the clear.
    task automatic reset_clear(input int glitch, input bit hold5);
        logic [7:0] dout; logic rdv, err, rdy, bsy;
        int  cnt [2];
        bit  was [2];
        int  saw_rdv, bad_rdy;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        if (hold5) drive(0, 1'b1, 1'b0, 8'd5, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, dout, rdv, err, rdy, bsy);
            chk("rst_busy", bsy, 1);
            chk("rst_ready", rdy, 0);
            chk("rst_data", dout, 0);
            chk("rst_rd_valid", rdv, 0);
            chk("rst_err", err, 0);
            exp_do[s] = 8'h00; exp_err[s] = 1'b0;
            for (int a = 0; a < 256; a++) mdl[s][a] = ini[s];
        end
        rst = 1'b0;
        if (glitch > 0) begin
            repeat (glitch) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        cnt = '{0, 0}; was = '{1'b1, 1'b1};
        saw_rdv = 0; bad_rdy = 0;
        for (int k = 0; k < 1000 && (was[0] || was[1]); k++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) begin
                sample(s, dout, rdv, err, rdy, bsy);
                if (was[s]) cnt[s]++;
                was[s] = bsy;
                if (rdy == bsy) bad_rdy++;
                if (rdv) saw_rdv++;
            end
        end
        chk("clear_len0", cnt[0], 256);
        chk("clear_len1", cnt[1], 200);
        chk("ready_vs_busy", bad_rdy, 0);
        chk("no_accept_while_busy", saw_rdv, 0);
        for (int s = 0; s < 2; s++) begin
            sample(s, dout, rdv, err, rdy, bsy);
            chk("post_clear_ready", rdy, 1);
            chk("post_clear_busy", bsy, 0);
        end
        if (hold5) begin
            @(posedge clk); #1;
            exp_do[0] = mdl[0][5]; exp_err[0] = 1'b0;
            sample(0, dout, rdv, err, rdy, bsy);
            chk("held_rd_valid", rdv, 1);
            chk("held_data", dout, exp_do[0]);
            idle(0);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;

        reset_clear(0, 1'b0);
        op(0, 1'b0, 8'd0, 8'h00);
        op(0, 1'b0, 8'd128, 8'h00);
        op(0, 1'b0, 8'd255, 8'h00);
        idle(0);

        op(0, 1'b1, 8'd0, 8'hFF);
        op(0, 1'b1, 8'd2, 8'hAA);
        op(0, 1'b1, 8'd3, 8'hF0);
        op(0, 1'b0, 8'd0, 8'h00);
        op(0, 1'b0, 8'd2, 8'h00);
        op(0, 1'b0, 8'd3, 8'h00);
        idle(0);
        chk("hold_F0", bus0.data_out, 8'hF0);
        idle(0);

        op(0, 1'b1, 8'd7, 8'h3C);
        op(0, 1'b0, 8'd7, 8'h00);
        idle(0);

        op(1, 1'b1, 8'd250, 8'h55);
        op(1, 1'b0, 8'd250, 8'h00);
        op(1, 1'b0, 8'd199, 8'h00);
        idle(1);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 400; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 2) idle(s);
                else op(s, r < 5, 8'($urandom_range(0, 255)), 8'($urandom));
            end
            idle(s);
        end

        op(0, 1'b1, 8'd10, 8'h77);
        idle(0);
        reset_clear(100, 1'b0);
        op(0, 1'b0, 8'd10, 8'h00);
        chk("clr_addr10", bus0.data_out, 8'h00);
        idle(0);

        reset_clear(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
